fetch_stage: RTL and testbench

//  Instruction-fetch stage: owns the PC, issues reads to instruction memory, and holds the IF/ID register.

---
 rtl/fetch_stage_pkg.sv | 31 +++
 rtl/fetch_skid_buf.sv | 35 +++
 rtl/fetch_stage.sv | 155 +++++++++++++++
 tb/tb_fetch_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage and the logic that
// consumes its outputs (decode, control, hazard detection).
//   OP_HALT / OP_NOP : opcode field values (instruction bits [15:11])
//   NOP_INSTR_DEF    : instruction word injected into IF/ID on reset/flush
//   fetch_state_t    : fetch FSM states
//   if_id_t          : one IF/ID entry {instr, pc_plus2}
//   is_halt()        : opcode decode for HALT
package fetch_stage_pkg;

    localparam logic [4:0]  OP_HALT       = 5'b00000;
    localparam logic [4:0]  OP_NOP        = 5'b00001;
    localparam logic [15:0] NOP_INSTR_DEF = {OP_NOP, 11'b0};

    typedef enum logic [2:0] {
        ST_WARM,
        ST_FETCH,
        ST_WAIT,
        ST_DISCARD,
        ST_HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_plus2;
    } if_id_t;

    function automatic logic is_halt(input logic [15:0] word);
        return word[15:11] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding an IF/ID entry that arrived while decode
// was stalled.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture din (buffer becomes full)
//   drain    : entry consumed by IF/ID (buffer becomes empty)
//   clear    : discard the entry (redirect)
//   din      : entry to capture
//   full     : buffer holds a valid entry
//   dout     : buffered entry
module fetch_skid_buf
    import fetch_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   drain,
    input  logic   clear,
    input  if_id_t din,
    output logic   full,
    output if_id_t dout
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            full <= 1'b0;
            dout <= '0;
        end else if (load) begin
            full <= 1'b1;
            dout <= din;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues reads to instruction memory
// and holds the IF/ID register feeding decode.
//   clk, rst     : clock, synchronous active-high reset
//   stall        : decode cannot accept; IF/ID held
//   redirect     : taken branch/jump this cycle, target on redirect_pc
//   redirect_pc  : redirect target (bit 0 forced to 0)
//   imem_rdata   : instruction word from memory
//   imem_done    : imem_rdata valid this cycle
//   imem_rd      : read request, held until imem_done
//   imem_addr    : read address, stable while imem_rd is high
//   instruc      : IF/ID instruction
//   pc_plus2     : IF/ID PC+2 of instruc
//   inst_valid   : instruc is a real fetched instruction
//   late_rst     : 0 = decode treats instruc as NOP
//   halted       : HALT fetched, fetch frozen
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    output logic [15:0] instruc,
    output logic [15:0] pc_plus2,
    output logic        inst_valid,
    output logic        late_rst,
    output logic        halted
);

    fetch_state_t state;
    logic [15:0]  pc;
    logic [15:0]  pc_inc;
    logic [15:0]  redirect_tgt;
    logic [15:0]  reset_pc_al;

    logic         accept;
    logic         skid_load;
    logic         skid_drain;
    logic         skid_clear;
    logic         skid_full;
    if_id_t       skid_out;
    if_id_t       resp;

    assign pc_inc       = pc + 16'd2;
    assign redirect_tgt = redirect_pc & 16'hFFFE;
    assign reset_pc_al  = RESET_PC & 16'hFFFE;

    always_comb begin
        accept     = imem_rd && imem_done && !redirect &&
                     ((state == ST_FETCH) || (state == ST_WAIT));
        // imem_rd is low whenever the skid is full, so a drain and an
        // accepted response never coincide.
        skid_drain = skid_full && !stall && !redirect && (state == ST_FETCH);
        skid_load  = accept && stall;
        skid_clear = redirect && (state != ST_WARM);
        resp       = '{instr: imem_rdata, pc_plus2: pc_inc};
    end

    fetch_skid_buf u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .drain (skid_drain),
        .clear (skid_clear),
        .din   (resp),
        .full  (skid_full),
        .dout  (skid_out)
    );

    // imem_addr is a separate register from pc so that it stays on the
    // squashed address while DISCARD waits out the in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_WARM;
            pc         <= reset_pc_al;
            imem_addr  <= reset_pc_al;
            imem_rd    <= 1'b0;
            instruc    <= NOP_INSTR;
            pc_plus2   <= '0;
            inst_valid <= 1'b0;
            late_rst   <= 1'b0;
            halted     <= 1'b0;
        end else if (state == ST_WARM) begin
            state    <= ST_FETCH;
            late_rst <= 1'b1;
            imem_rd  <= 1'b1;
        end else if (redirect) begin
            pc         <= redirect_tgt;
            instruc    <= NOP_INSTR;
            inst_valid <= 1'b0;
            halted     <= 1'b0;
            imem_rd    <= 1'b1;
            if (imem_rd && !imem_done) begin
                state <= ST_DISCARD;
            end else begin
                state     <= ST_FETCH;
                imem_addr <= redirect_tgt;
            end
        end else begin
            case (state)
                ST_FETCH, ST_WAIT: begin
                    if (skid_drain) begin
                        instruc    <= skid_out.instr;
                        pc_plus2   <= skid_out.pc_plus2;
                        inst_valid <= 1'b1;
                        if (is_halt(skid_out.instr)) begin
                            state   <= ST_HALTED;
                            halted  <= 1'b1;
                            imem_rd <= 1'b0;
                        end else begin
                            imem_rd <= 1'b1;
                        end
                    end else if (accept) begin
                        pc        <= pc_inc;
                        imem_addr <= pc_inc;
                        state     <= ST_FETCH;
                        if (stall) begin
                            imem_rd <= 1'b0;
                        end else begin
                            instruc    <= imem_rdata;
                            pc_plus2   <= pc_inc;
                            inst_valid <= 1'b1;
                            if (is_halt(imem_rdata)) begin
                                state   <= ST_HALTED;
                                halted  <= 1'b1;
                                imem_rd <= 1'b0;
                            end else begin
                                imem_rd <= 1'b1;
                            end
                        end
                    end else if (imem_rd) begin
                        state <= ST_WAIT;
                    end
                end
                ST_DISCARD: begin
                    if (imem_done) begin
                        state     <= ST_FETCH;
                        imem_addr <= pc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_rdata;
    logic        imem_done;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] instruc;
    logic [15:0] pc_plus2;
    logic        inst_valid;
    logic        late_rst;
    logic        halted;

    int checks = 0;
    int errors = 0;

    // memory model: latency cycles of wait after the request appears
    logic [2:0]  lat;
    logic [2:0]  wcnt;
    logic        halt_en;
    logic [15:0] halt_addr;

    fetch_stage #(
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0800)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_rdata  (imem_rdata),
        .imem_done   (imem_done),
        .imem_rd     (imem_rd),
        .imem_addr   (imem_addr),
        .instruc     (instruc),
        .pc_plus2    (pc_plus2),
        .inst_valid  (inst_valid),
        .late_rst    (late_rst),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a, input logic hen,
                                             input logic [15:0] ha);
        logic [15:0] w;
        if (hen && a == ha) return 16'h0000;
        w = 16'hC001 + (a >> 1) * 16'h0801;
        if (w[15:11] == 5'b00000) w[15] = 1'b1;
        return w;
    endfunction

    always @(posedge clk) begin
        if (rst || !imem_rd || imem_done) wcnt <= 3'd0;
        else                              wcnt <= wcnt + 3'd1;
    end

    assign imem_done = imem_rd && (wcnt == lat);
    always_comb imem_rdata = mem_word(imem_addr, halt_en, halt_addr);

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (instruc !== 16'h0800) begin errors++; $display("FAIL reset_instruc: got %h expected 0800", instruc); end
        checks++; if (pc_plus2 !== 16'h0000) begin errors++; $display("FAIL reset_pc_plus2: got %h expected 0000", pc_plus2); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
        checks++; if (late_rst !== 1'b0) begin errors++; $display("FAIL reset_late_rst: got %b expected 0", late_rst); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL reset_imem_rd: got %b expected 0", imem_rd); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_imem_addr: got %h expected 0000", imem_addr); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (late_rst !== 1'b1) begin errors++; $display("FAIL warm_late_rst: got %b expected 1", late_rst); end
        checks++; if (imem_rd !== 1'b1) begin errors++; $display("FAIL warm_imem_rd: got %b expected 1", imem_rd); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL warm_imem_addr: got %h expected 0000", imem_addr); end
    endtask

    task automatic test_basic_fetch();
        @(negedge clk);
        checks++; if (instruc !== 16'hC001) begin errors++; $display("FAIL fetch0_instruc: got %h expected C001", instruc); end
        checks++; if (pc_plus2 !== 16'h0002) begin errors++; $display("FAIL fetch0_pc_plus2: got %h expected 0002", pc_plus2); end
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL fetch0_inst_valid: got %b expected 1", inst_valid); end
        checks++; if (imem_addr !== 16'h0002) begin errors++; $display("FAIL fetch0_imem_addr: got %h expected 0002", imem_addr); end
        @(negedge clk);
        checks++; if (instruc !== 16'hC802) begin errors++; $display("FAIL fetch1_instruc: got %h expected C802", instruc); end
        checks++; if (pc_plus2 !== 16'h0004) begin errors++; $display("FAIL fetch1_pc_plus2: got %h expected 0004", pc_plus2); end
        checks++; if (imem_addr !== 16'h0004) begin errors++; $display("FAIL fetch1_imem_addr: got %h expected 0004", imem_addr); end
    endtask

    task automatic test_stall_skid();
        stall = 1'b1;
        @(negedge clk);
        checks++; if (instruc !== 16'hC802) begin errors++; $display("FAIL stall_instruc: got %h expected C802", instruc); end
        checks++; if (pc_plus2 !== 16'h0004) begin errors++; $display("FAIL stall_pc_plus2: got %h expected 0004", pc_plus2); end
        checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL stall_imem_rd: got %b expected 0", imem_rd); end
        checks++; if (imem_addr !== 16'h0006) begin errors++; $display("FAIL stall_imem_addr: got %h expected 0006", imem_addr); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL stall_hold_imem_rd[%0d]: got %b expected 0", i, imem_rd); end
            checks++; if (instruc !== 16'hC802) begin errors++; $display("FAIL stall_hold_instruc[%0d]: got %h expected C802", i, instruc); end
        end
        stall = 1'b0;
        @(negedge clk);
        checks++; if (instruc !== 16'hD003) begin errors++; $display("FAIL drain_instruc: got %h expected D003", instruc); end
        checks++; if (pc_plus2 !== 16'h0006) begin errors++; $display("FAIL drain_pc_plus2: got %h expected 0006", pc_plus2); end
        checks++; if (imem_rd !== 1'b1) begin errors++; $display("FAIL drain_imem_rd: got %b expected 1", imem_rd); end
        checks++; if (imem_addr !== 16'h0006) begin errors++; $display("FAIL drain_imem_addr: got %h expected 0006", imem_addr); end
        @(negedge clk);
        checks++; if (instruc !== 16'hD804) begin errors++; $display("FAIL after_drain_instruc: got %h expected D804", instruc); end
        checks++; if (pc_plus2 !== 16'h0008) begin errors++; $display("FAIL after_drain_pc_plus2: got %h expected 0008", pc_plus2); end
    endtask

    task automatic test_redirect_wait();
        lat = 3'd3;
        apply_reset();
        @(negedge clk);
        checks++; if (imem_rd !== 1'b1) begin errors++; $display("FAIL wait_imem_rd: got %b expected 1", imem_rd); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL wait_inst_valid: got %b expected 0", inst_valid); end
        redirect    = 1'b1;
        redirect_pc = 16'h0041;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL discard_imem_addr: got %h expected 0000", imem_addr); end
        checks++; if (imem_rd !== 1'b1) begin errors++; $display("FAIL discard_imem_rd: got %b expected 1", imem_rd); end
        checks++; if (instruc !== 16'h0800) begin errors++; $display("FAIL discard_instruc: got %h expected 0800", instruc); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (imem_addr !== 16'h0040) begin errors++; $display("FAIL redir_imem_addr: got %h expected 0040", imem_addr); end
        checks++; if (instruc !== 16'h0800) begin errors++; $display("FAIL redir_dropped_instruc: got %h expected 0800", instruc); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_inst_valid: got %b expected 0", inst_valid); end
        for (int i = 0; i < 4; i++) @(negedge clk);
        checks++; if (instruc !== 16'hC021) begin errors++; $display("FAIL redir_fetch_instruc: got %h expected C021", instruc); end
        checks++; if (pc_plus2 !== 16'h0042) begin errors++; $display("FAIL redir_fetch_pc_plus2: got %h expected 0042", pc_plus2); end
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL redir_fetch_inst_valid: got %b expected 1", inst_valid); end
    endtask

    task automatic test_halt();
        lat       = 3'd0;
        halt_en   = 1'b1;
        halt_addr = 16'h0008;
        apply_reset();
        for (int i = 0; i < 4; i++) @(negedge clk);
        checks++; if (imem_addr !== 16'h0008) begin errors++; $display("FAIL halt_pre_addr: got %h expected 0008", imem_addr); end
        @(negedge clk);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_halted: got %b expected 1", halted); end
        checks++; if (instruc !== 16'h0000) begin errors++; $display("FAIL halt_instruc: got %h expected 0000", instruc); end
        checks++; if (pc_plus2 !== 16'h000A) begin errors++; $display("FAIL halt_pc_plus2: got %h expected 000A", pc_plus2); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL halt_imem_rd[%0d]: got %b expected 0", i, imem_rd); end
            @(negedge clk);
        end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_stays: got %b expected 1", halted); end
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL unhalt_halted: got %b expected 0", halted); end
        checks++; if (imem_rd !== 1'b1) begin errors++; $display("FAIL unhalt_imem_rd: got %b expected 1", imem_rd); end
        checks++; if (imem_addr !== 16'h0020) begin errors++; $display("FAIL unhalt_imem_addr: got %h expected 0020", imem_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL unhalt_inst_valid: got %b expected 0", inst_valid); end
        @(negedge clk);
        checks++; if (instruc !== 16'h4011) begin errors++; $display("FAIL unhalt_instruc: got %h expected 4011", instruc); end
        checks++; if (pc_plus2 !== 16'h0022) begin errors++; $display("FAIL unhalt_pc_plus2: got %h expected 0022", pc_plus2); end
        halt_en = 1'b0;
    endtask

    task automatic test_wrap_and_drop();
        lat = 3'd0;
        apply_reset();
        redirect    = 1'b1;
        redirect_pc = 16'hFFFC;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (imem_addr !== 16'hFFFC) begin errors++; $display("FAIL wrap_addr0: got %h expected FFFC", imem_addr); end
        checks++; if (instruc !== 16'h0800) begin errors++; $display("FAIL wrap_drop0_instruc: got %h expected 0800", instruc); end
        @(negedge clk);
        checks++; if (instruc !== 16'h2FFF) begin errors++; $display("FAIL wrap_instruc1: got %h expected 2FFF", instruc); end
        checks++; if (pc_plus2 !== 16'hFFFE) begin errors++; $display("FAIL wrap_pc_plus2_1: got %h expected FFFE", pc_plus2); end
        @(negedge clk);
        checks++; if (instruc !== 16'h3800) begin errors++; $display("FAIL wrap_instruc2: got %h expected 3800", instruc); end
        checks++; if (pc_plus2 !== 16'h0000) begin errors++; $display("FAIL wrap_pc_plus2_2: got %h expected 0000", pc_plus2); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_addr2: got %h expected 0000", imem_addr); end
        redirect    = 1'b1;
        redirect_pc = 16'h0011;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (instruc !== 16'h0800) begin errors++; $display("FAIL drop_instruc: got %h expected 0800", instruc); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL drop_inst_valid: got %b expected 0", inst_valid); end
        checks++; if (imem_addr !== 16'h0010) begin errors++; $display("FAIL drop_addr: got %h expected 0010", imem_addr); end
        @(negedge clk);
        checks++; if (instruc !== 16'h8009) begin errors++; $display("FAIL drop_next_instruc: got %h expected 8009", instruc); end
        checks++; if (pc_plus2 !== 16'h0012) begin errors++; $display("FAIL drop_next_pc_plus2: got %h expected 0012", pc_plus2); end
    endtask

    task automatic test_reset_in_wait();
        lat = 3'd0;
        apply_reset();
        @(negedge clk);
        @(negedge clk);
        checks++; if (instruc !== 16'hC802) begin errors++; $display("FAIL prerst_instruc: got %h expected C802", instruc); end
        lat = 3'd3;
        @(negedge clk);
        checks++; if (imem_rd !== 1'b1) begin errors++; $display("FAIL prerst_imem_rd: got %b expected 1", imem_rd); end
        stall = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        checks++; if (instruc !== 16'h0800) begin errors++; $display("FAIL midrst_instruc: got %h expected 0800", instruc); end
        checks++; if (pc_plus2 !== 16'h0000) begin errors++; $display("FAIL midrst_pc_plus2: got %h expected 0000", pc_plus2); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL midrst_inst_valid: got %b expected 0", inst_valid); end
        checks++; if (late_rst !== 1'b0) begin errors++; $display("FAIL midrst_late_rst: got %b expected 0", late_rst); end
        checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL midrst_imem_rd: got %b expected 0", imem_rd); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL midrst_imem_addr: got %h expected 0000", imem_addr); end
        rst   = 1'b0;
        stall = 1'b0;
        lat   = 3'd0;
        @(negedge clk);
        checks++; if (late_rst !== 1'b1) begin errors++; $display("FAIL restart_late_rst: got %b expected 1", late_rst); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL restart_addr: got %h expected 0000", imem_addr); end
        @(negedge clk);
        checks++; if (instruc !== 16'hC001) begin errors++; $display("FAIL restart_instruc: got %h expected C001", instruc); end
        checks++; if (pc_plus2 !== 16'h0002) begin errors++; $display("FAIL restart_pc_plus2: got %h expected 0002", pc_plus2); end
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        lat         = 3'd0;
        halt_en     = 1'b0;
        halt_addr   = 16'h0000;
        test_reset();
        test_basic_fetch();
        test_stall_skid();
        test_redirect_wait();
        test_halt();
        test_wrap_and_drop();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
